// File: rtl/simeck_pkg.sv
// simeck_pkg: constants, FSM encoding and the Simeck mixing function shared
// by the key schedule and the round stage.
//   NUM_ROUNDS : round keys per key load
//   RC_CONST   : round constant C
//   LFSR_INIT  : seed of the z-sequence LFSR
//   state_t    : key schedule FSM states
//   f()        : (x & rotl(x,5)) ^ rotl(x,1)
package simeck_pkg;

   localparam int          NUM_ROUNDS = 32;
   localparam logic [15:0] RC_CONST   = 16'hFFFC;
   localparam logic [4:0]  LFSR_INIT  = 5'b11111;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   function automatic logic [15:0] f(input logic [15:0] x);
      return (x & {x[10:0], x[15:11]}) ^ {x[14:0], x[15]};
   endfunction

endpackage

// File: rtl/simeck_key_schedule_if.sv
// simeck_key_schedule_if: request/round-key bus of the Simeck key schedule.
//   start, key       : load request and 64-bit master key (master -> slave)
//   rk_ready         : downstream accepts the round key (master -> slave)
//   rk_valid, rk     : round key and its qualifier (slave -> master)
//   rk_idx           : round index of rk (slave -> master)
//   busy, done       : schedule in progress / one-cycle completion pulse
interface simeck_key_schedule_if;

   logic        start;
   logic [63:0] key;
   logic        rk_ready;
   logic        rk_valid;
   logic [15:0] rk;
   logic [4:0]  rk_idx;
   logic        busy;
   logic        done;

   modport master (
      output start, key, rk_ready,
      input  rk_valid, rk, rk_idx, busy, done
   );

   modport slave (
      input  start, key, rk_ready,
      output rk_valid, rk, rk_idx, busy, done
   );

endinterface

// File: rtl/simeck_lfsr5.sv
// simeck_lfsr5: 5-bit LFSR producing the z-sequence of the Simeck key schedule.
//   clk, rst : clock, asynchronous active-low reset
//   i_load   : reseed to LFSR_INIT
//   i_adv    : advance one step
//   o_z      : current sequence bit s[0]
module simeck_lfsr5
   import simeck_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  logic i_adv,
   output logic o_z
);

   logic [4:0] r_s;

   // x^5 + x^2 + 1 recurrence, shifted toward bit 0
   always_ff @(posedge clk or negedge rst)
      if (!rst)
         r_s <= LFSR_INIT;
      else if (i_load)
         r_s <= LFSR_INIT;
      else if (i_adv)
         r_s <= {r_s[2] ^ r_s[0], r_s[4:1]};

   assign o_z = r_s[0];

endmodule

// File: rtl/simeck_key_schedule.sv
// simeck_key_schedule: Simeck32/64 key schedule emitting NUM_ROUNDS round keys
// per key load over a valid/ready handshake.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : simeck_key_schedule_if.slave (start/key in, rk/rk_idx/rk_valid
//              out, rk_ready in, busy/done status out)
module simeck_key_schedule
   import simeck_pkg::*;
#(
   parameter int          NUM_ROUNDS = simeck_pkg::NUM_ROUNDS,
   parameter logic [15:0] RC_CONST   = simeck_pkg::RC_CONST
)(
   input logic                  clk,
   input logic                  rst,
   simeck_key_schedule_if.slave bus
);

   state_t           r_state;
   state_t           w_next;
   logic [3:0][15:0] r_w;
   logic [4:0]       r_idx;
   logic             w_load;
   logic             w_hs;
   logic             w_last;
   logic             w_z;

   assign w_load = (r_state == IDLE) && bus.start;
   assign w_hs   = (r_state == RUN) && bus.rk_ready;
   assign w_last = r_idx == 5'(NUM_ROUNDS - 1);

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = bus.start ? RUN : IDLE;
         RUN:     w_next = (w_hs && w_last) ? DONE : RUN;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst)
         r_state <= IDLE;
      else
         r_state <= w_next;

   // Word window W0..W3 is a packed array so the key loads with W0 = key[15:0]
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_w   <= '0;
         r_idx <= '0;
      end else if (w_load) begin
         r_w   <= bus.key;
         r_idx <= '0;
      end else if (w_hs) begin
         r_w   <= {r_w[0] ^ f(r_w[1]) ^ RC_CONST ^ {15'b0, w_z}, r_w[3:1]};
         r_idx <= r_idx + 5'd1;
      end

   simeck_lfsr5 u_lfsr (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load),
      .i_adv  (w_hs),
      .o_z    (w_z)
   );

   assign bus.rk_valid = r_state == RUN;
   assign bus.rk       = r_w[0];
   assign bus.rk_idx   = r_idx;
   assign bus.busy     = r_state == RUN;
   assign bus.done     = r_state == DONE;

endmodule

// File: tb/tb_simeck_key_schedule.sv
// tb_simeck_key_schedule: scoreboard bench for simeck_key_schedule.
module tb_simeck_key_schedule;

   localparam logic [63:0] K_REF = 64'h1918_1110_0908_0100;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   simeck_key_schedule_if bus();

   simeck_key_schedule dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          chk = 0;
   int          err = 0;
   logic [20:0] exp_q[$];
   logic [15:0] rx[32];
   int          hs_cnt = 0;
   int          stall_cnt = 0;
   int          busy_cnt = 0;
   int          done_cnt = 0;
   logic        held_v = 1'b0;
   logic [15:0] held_rk;
   logic [4:0]  held_idx;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] rol(input logic [15:0] x, input int n);
      logic [31:0] d;
      d = {x, x} << n;
      return d[31:16];
   endfunction

   function automatic logic [15:0] fm(input logic [15:0] x);
      return (x & rol(x, 5)) ^ rol(x, 1);
   endfunction

   // Reference: word recurrence w[i+4] = w[i] ^ f(w[i+1]) ^ C ^ z[i], with z
   // the m-sequence z[j] = z[j-3] ^ z[j-5] seeded with five ones.
   task automatic push_model(input logic [63:0] k);
      logic [15:0] w[36];
      logic        z[32];
      for (int i = 0; i < 4; i++) w[i] = k[16*i +: 16];
      for (int i = 0; i < 32; i++) z[i] = (i < 5) ? 1'b1 : z[i-3] ^ z[i-5];
      for (int i = 0; i < 32; i++) w[i+4] = w[i] ^ fm(w[i+1]) ^ 16'hFFFC ^ {15'b0, z[i]};
      for (int i = 0; i < 32; i++) exp_q.push_back({5'(i), w[i]});
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         exp_q.delete();
         held_v    = 1'b0;
         hs_cnt    = 0;
         stall_cnt = 0;
         busy_cnt  = 0;
      end else begin
         logic [20:0] e;
         if (bus.busy) busy_cnt++;
         if (held_v) begin
            check("hold_valid", bus.rk_valid, 1);
            check("hold_rk", bus.rk, held_rk);
            check("hold_idx", bus.rk_idx, held_idx);
         end
         held_v   = bus.rk_valid && !bus.rk_ready;
         held_rk  = bus.rk;
         held_idx = bus.rk_idx;
         if (held_v) stall_cnt++;
         if (bus.rk_valid && bus.rk_ready) begin
            if (exp_q.size() == 0) begin
               chk++;
               err++;
               $display("FAIL extra_rk: got idx %0d rk %h, expected no key", bus.rk_idx, bus.rk);
            end else begin
               e = exp_q.pop_front();
               check("rk", bus.rk, e[15:0]);
               check("rk_idx", bus.rk_idx, e[20:16]);
            end
            rx[bus.rk_idx] = bus.rk;
            hs_cnt++;
         end
         if (bus.done) begin
            check("hs_count", hs_cnt, 32);
            check("busy_cycles", busy_cnt, 32 + stall_cnt);
            check("valid_at_done", bus.rk_valid, 0);
            check("queue_empty", exp_q.size(), 0);
            done_cnt++;
            hs_cnt    = 0;
            busy_cnt  = 0;
            stall_cnt = 0;
         end
      end
   end

   // mode 0: rk_ready held high; mode 1: rk_ready random
   task automatic run(input logic [63:0] k, input int mode, input bit disturb, input bit do_rst);
      int cyc;
      int d0;
      push_model(k);
      d0 = done_cnt;
      @(posedge clk); #1;
      bus.start    = 1'b1;
      bus.key      = k;
      bus.rk_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.key   = {$urandom, $urandom};
      check("first_valid", bus.rk_valid, 1);
      check("first_idx", bus.rk_idx, 0);
      check("first_rk", bus.rk, k[15:0]);
      cyc = 0;
      while (!bus.done && cyc < 2000) begin
         if (mode != 0) bus.rk_ready = 1'($urandom_range(0, 1));
         if (disturb) begin
            bus.start = bus.rk_idx == 5'd10;
            bus.key   = {$urandom, $urandom};
         end
         if (do_rst && bus.rk_valid && bus.rk_idx == 5'd7) begin
            #2 rst = 1'b0;
            #1;
            check("arst_valid", bus.rk_valid, 0);
            check("arst_rk", bus.rk, 0);
            check("arst_idx", bus.rk_idx, 0);
            check("arst_busy", bus.busy, 0);
            check("arst_done", bus.done, 0);
            @(posedge clk); #1;
            rst = 1'b1;
            bus.start = 1'b0;
            @(posedge clk); #1;
            check("idle_after_rst", bus.busy, 0);
            check("novalid_after_rst", bus.rk_valid, 0);
            return;
         end
         @(posedge clk); #1;
         cyc++;
      end
      if (!bus.done) begin
         chk++;
         err++;
         $display("FAIL timeout: done not seen after %0d cycles", cyc);
      end
      bus.start = disturb;
      bus.key   = {$urandom, $urandom};
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("done_pulse", bus.done, 0);
      check("done_count", done_cnt, d0 + 1);
      check("idle_busy", bus.busy, 0);
      check("idle_valid", bus.rk_valid, 0);
   endtask

   initial begin
      logic [15:0] l, r, t;
      bus.start    = 1'b0;
      bus.key      = '0;
      bus.rk_ready = 1'b0;
      #12;
      check("rst_valid", bus.rk_valid, 0);
      check("rst_rk", bus.rk, 0);
      check("rst_idx", bus.rk_idx, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      rst = 1'b1;
      run(K_REF, 0, 1'b0, 1'b0);
      l = 16'h6565;
      r = 16'h6877;
      for (int i = 0; i < 32; i++) begin
         t = l;
         l = r ^ fm(l) ^ rx[i];
         r = t;
      end
      check("ciphertext", {l, r}, 32'h770D_2C76);
      run(K_REF, 1, 1'b0, 1'b0);
      run({$urandom, $urandom}, 1, 1'b1, 1'b0);
      run({$urandom, $urandom}, 1, 1'b0, 1'b1);
      run(K_REF, 1, 1'b0, 1'b0);
      repeat (3) run({$urandom, $urandom}, 1, 1'b0, 1'b0);
      run({$urandom, $urandom}, 0, 1'b1, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", chk, err);
      $finish;
   end

endmodule

// File: doc/simeck_key_schedule.md
SIMECK_KEY_SCHEDULE -- requirements
Module: simeck_key_schedule

Interface
REQ-001 Parameter: NUM_ROUNDS, default 32, number of 16-bit round keys produced per key load.
REQ-002 Parameter: RC_CONST, default 16'hFFFC, round constant C.
REQ-003 clk  input  1  clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  request to load key and begin a schedule; accepted only in IDLE.
REQ-006 key  input  64  master key; words k3..k0 = key[63:48], key[47:32], key[31:16], key[15:0]; sampled on start acceptance.
REQ-007 rk_ready  input  1  downstream round stage accepts rk this cycle.
REQ-008 rk_valid  output  1  rk and rk_idx hold a valid round key.
REQ-009 rk  output  16  current round key, feeds the round stage key port.
REQ-010 rk_idx  output  5  round index of rk, 0..NUM_ROUNDS-1.
REQ-011 busy  output  1  high from start acceptance until the final handshake.
REQ-012 done  output  1  single-cycle pulse the cycle after the final handshake.

Function
REQ-013 FSM states SHALL be IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on handshake with rk_idx==NUM_ROUNDS-1; DONE->IDLE unconditionally next cycle.
REQ-014 On start in IDLE, the block SHALL load a 4-word register W0..W3 = k0..k3, set the LFSR to 5'b11111, clear rk_idx, and assert rk_valid the next cycle (latency 1).
REQ-015 rk SHALL equal W0 at all times in RUN.
REQ-016 Handshake = rk_valid & rk_ready; on handshake W shifts: W0<=W1, W1<=W2, W2<=W3, W3<=W0 ^ f(W1) ^ RC_CONST ^ {15'b0, z}, and rk_idx increments.
REQ-017 f(x) SHALL be (x & rotl(x,5)) ^ rotl(x,1), 16-bit rotates.
REQ-018 z SHALL be LFSR bit s[0]; on each handshake the LFSR advances s <= {s[2]^s[0], s[4:1]}.
REQ-019 Without handshake, rk, rk_idx, rk_valid, W and LFSR SHALL hold unchanged (backpressure of any length).
REQ-020 rk_valid SHALL deassert in the cycle after the final (index NUM_ROUNDS-1) handshake; no key beyond index NUM_ROUNDS-1 is emitted.
REQ-021 start while in RUN or DONE SHALL be ignored; key changes outside the acceptance cycle SHALL have no effect.
REQ-022 start asserted in the same cycle as done SHALL be ignored; a new schedule begins only from IDLE.
REQ-023 All arithmetic is 16-bit XOR/AND/rotate; no carries, no width extension.

Reset
REQ-024 rst low SHALL force IDLE, rk_valid=0, rk=16'h0000, rk_idx=0, busy=0, done=0, W=0, LFSR=5'b11111, independent of clk.
REQ-025 rst asserted mid-RUN SHALL abort the schedule; after release the block waits in IDLE for a fresh start.

Structure
REQ-026 Shared package simeck_pkg SHALL hold NUM_ROUNDS, RC_CONST, LFSR_INIT=5'b11111, the FSM state encoding, and the f() definition, shared with the round stage.
REQ-027 One sub-module simeck_lfsr5 (load, advance, 5-bit state, z output) SHALL be instantiated; the rest is flat.

Verification
REQ-028 key=64'h1918_1110_0908_0100, start, rk_ready=1 -> rk 0x0100,0x0908,0x1110,0x1918,0xEDED at rk_idx 0..4, first valid 1 cycle after start.
REQ-029 Same key, rk_ready toggled pseudo-randomly -> identical 32-key sequence to REQ-028 run; rk stable while rk_valid & !rk_ready.
REQ-030 rk_ready=1 throughout -> exactly 32 handshakes, busy high 32 cycles, done single pulse, rk_valid low afterward.
REQ-031 start pulsed at rk_idx=10 with different key -> sequence unaffected; start at done cycle -> ignored, IDLE reached.
REQ-032 rst low at rk_idx=7 -> all outputs reset values immediately; new start after release -> rk_idx 0, rk=0x0100.
REQ-033 Chained with the round stage, 32 rounds on plaintext 0x6565_6877 -> ciphertext 0x770D_2C76.
